// File: rtl/ntt_cmd_arbiter_if.sv
// Signal bundle shared by the command requesters, the arbiter and the NTT engine.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ntt_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*8-1:0]  req_opcode;
  logic [NUM_REQ*4-1:0]  req_slot;
  logic [NUM_REQ*48-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_done;
  logic                  cmd_valid;
  logic [7:0]            cmd_opcode;
  logic [3:0]            cmd_slot;
  logic [47:0]           cmd_dma_addr;
  logic                  engine_ready;
  logic                  busy;
  logic [REQ_W-1:0]      owner;
  logic [23:0]           busy_cycles;
  logic                  err_timeout;
  logic                  err_clr;

  modport slave (
    input  req_valid, req_opcode, req_slot, req_addr, engine_ready, err_clr,
    output req_ready, req_done, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr,
           busy, owner, busy_cycles, err_timeout
  );

  modport master (
    output req_valid, req_opcode, req_slot, req_addr, engine_ready, err_clr,
    input  req_ready, req_done, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr,
           busy, owner, busy_cycles, err_timeout
  );
endinterface

// File: rtl/ntt_cmd_arbiter.sv
// Round-robin arbiter sharing one ntt_engine command port between NUM_REQ sources,
// with completion routing, busy-time measurement and a sticky hang watchdog.
module ntt_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  ntt_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [REQ_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]    owner_q, owner_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [3:0]          slot_q, slot_d;
  logic [47:0]         addr_q, addr_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [23:0]         busy_cycles_q, busy_cycles_d;
  logic                err_q, err_d;

  logic                found;
  logic [REQ_W-1:0]    sel;
  logic [REQ_W:0]      idx;
  logic [NUM_REQ-1:0]  owner_oh;

  // First pending requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (REQ_W+1)'(i);
      if (idx >= (REQ_W+1)'(NUM_REQ)) idx = idx - (REQ_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[idx[REQ_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[REQ_W-1:0];
      end
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    opcode_d      = opcode_q;
    slot_d        = slot_q;
    addr_d        = addr_q;
    done_d        = '0;
    cnt_d         = cnt_q;
    busy_cycles_d = busy_cycles_q;
    err_d         = err_q;
    if (bus.err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.engine_ready && found) begin
          owner_d  = sel;
          rr_ptr_d = (sel == REQ_W'(NUM_REQ-1)) ? '0 : sel + REQ_W'(1);
          opcode_d = bus.req_opcode[int'(sel)*8 +: 8];
          slot_d   = bus.req_slot[int'(sel)*4 +: 4];
          addr_d   = bus.req_addr[int'(sel)*48 +: 48];
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      // The engine drops ready only one cycle after accepting, so ready is ignored here.
      HOLD: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.engine_ready) begin
          busy_cycles_d = cnt_q;
          done_d        = owner_oh;
          state_d       = IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 24'd1;
          if (cnt_d == 24'(TIMEOUT)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      opcode_q      <= '0;
      slot_q        <= '0;
      addr_q        <= '0;
      done_q        <= '0;
      cnt_q         <= '0;
      busy_cycles_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      opcode_q      <= opcode_d;
      slot_q        <= slot_d;
      addr_q        <= addr_d;
      done_q        <= done_d;
      cnt_q         <= cnt_d;
      busy_cycles_q <= busy_cycles_d;
      err_q         <= err_d;
    end
  end

  assign bus.cmd_valid    = (state_q == ISSUE);
  assign bus.req_ready    = (state_q == ISSUE) ? owner_oh : '0;
  assign bus.req_done     = done_q;
  assign bus.cmd_opcode   = opcode_q;
  assign bus.cmd_slot     = slot_q;
  assign bus.cmd_dma_addr = addr_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.owner        = owner_q;
  assign bus.busy_cycles  = busy_cycles_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_ntt_cmd_arbiter.sv
// Self-checking bench for ntt_cmd_arbiter: the bench plays requesters and engine and
// predicts grants, timing, busy_cycles and the watchdog from a transaction-level model.
module tb_ntt_cmd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int REQ_W   = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   model_ptr = 0;
  bit   err_exp = 1'b0;
  int   cv_count = 0;
  int   rdy_cnt [NUM_REQ];
  logic [7:0]  req_op [NUM_REQ];
  logic [3:0]  req_sl [NUM_REQ];
  logic [47:0] req_ad [NUM_REQ];

  ntt_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) bus ();

  ntt_cmd_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) cv_count++;
    for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] === 1'b1) rdy_cnt[i]++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang required finish");
    $fatal(1, "[TB] aborted");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] m, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (ptr + k) % NUM_REQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [7:0] op,
                         input logic [3:0] sl, input logic [47:0] ad);
    req_op[i] = op;
    req_sl[i] = sl;
    req_ad[i] = ad;
    bus.req_valid[i]           = v;
    bus.req_opcode[8*i +: 8]   = op;
    bus.req_slot[4*i +: 4]     = sl;
    bus.req_addr[48*i +: 48]   = ad;
  endtask

  task automatic set_rand(input int i, input logic v);
    set_req(i, v, 8'($urandom), 4'($urandom), 48'({$urandom, $urandom}));
  endtask

  task automatic do_reset();
    bus.req_valid    = '0;
    bus.engine_ready = 1'b1;
    bus.err_clr      = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    err_exp   = 1'b0;
  endtask

  // One command from the grant decision in IDLE through req_done.
  // mode: 0 owner drops, 1 owner keeps requesting, 2 owner re-raises at req_done.
  // clr:  0 none, 1 err_clr pulsed in the decision cycle, 2 err_clr held all along.
  task automatic do_command(input int lat, input int mode, input int clr, output int got);
    logic [NUM_REQ-1:0] oh;
    logic [7:0]  eop;
    logic [3:0]  esl;
    logic [47:0] ead;
    int g;
    bit eerr;
    got = -1;
    g = model_pick(bus.req_valid, model_ptr);
    if (g < 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL pick: got no pending request, required at least one");
      return;
    end
    oh = '0;
    oh[g] = 1'b1;
    eop = req_op[g];
    esl = req_sl[g];
    ead = req_ad[g];
    bus.err_clr = (clr != 0);
    tick();
    got  = int'(bus.owner);
    eerr = (clr != 0) ? 1'b0 : err_exp;
    tests_run++;
    if ({bus.cmd_valid, bus.req_ready, bus.req_done, bus.owner, bus.busy, bus.err_timeout} !==
        {1'b1, oh, 4'b0000, 2'(g), 1'b1, eerr}) begin
      tests_failed++;
      $display("[TB] FAIL issue: got vld=%b rdy=%b done=%b own=%0d busy=%b err=%b, required vld=1 rdy=%b done=0000 own=%0d busy=1 err=%b",
               bus.cmd_valid, bus.req_ready, bus.req_done, bus.owner, bus.busy, bus.err_timeout, oh, g, eerr);
    end
    tests_run++;
    if ({bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr} !== {eop, esl, ead}) begin
      tests_failed++;
      $display("[TB] FAIL issue_fields: got %h/%h/%h, required %h/%h/%h",
               bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr, eop, esl, ead);
    end
    model_ptr = (g + 1) % NUM_REQ;
    if (clr == 1) begin
      bus.err_clr = 1'b0;
      err_exp = 1'b0;
    end
    if (mode == 1) set_rand(g, 1'b1);
    else           set_rand(g, 1'b0);
    bus.engine_ready = 1'b0;
    tick();
    tests_run++;
    if ({bus.cmd_valid, bus.req_ready, bus.busy, bus.err_timeout, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr} !==
        {1'b0, 4'b0000, 1'b1, eerr, eop, esl, ead}) begin
      tests_failed++;
      $display("[TB] FAIL hold: got vld=%b rdy=%b busy=%b err=%b fields %h/%h/%h, required vld=0 rdy=0 busy=1 err=%b fields %h/%h/%h",
               bus.cmd_valid, bus.req_ready, bus.busy, bus.err_timeout, bus.cmd_opcode, bus.cmd_slot,
               bus.cmd_dma_addr, eerr, eop, esl, ead);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      eerr = (clr == 2) ? (k - 1 == TIMEOUT) : (err_exp || (k - 1 >= TIMEOUT));
      tests_run++;
      if ({bus.cmd_valid, bus.req_ready, bus.req_done, bus.busy, bus.err_timeout} !==
          {1'b0, 4'b0000, 4'b0000, 1'b1, eerr}) begin
        tests_failed++;
        $display("[TB] FAIL wait_cycle_%0d: got vld=%b rdy=%b done=%b busy=%b err=%b, required vld=0 rdy=0 done=0 busy=1 err=%b",
                 k, bus.cmd_valid, bus.req_ready, bus.req_done, bus.busy, bus.err_timeout, eerr);
      end
    end
    bus.engine_ready = 1'b1;
    tick();
    err_exp = (clr == 2) ? 1'b0 : (err_exp || (lat >= TIMEOUT));
    tests_run++;
    if ({bus.req_done, bus.busy, bus.cmd_valid, bus.owner, bus.busy_cycles, bus.err_timeout} !==
        {oh, 1'b0, 1'b0, 2'(g), 24'(lat), err_exp}) begin
      tests_failed++;
      $display("[TB] FAIL done: got done=%b busy=%b vld=%b own=%0d cycles=%0d err=%b, required done=%b busy=0 vld=0 own=%0d cycles=%0d err=%b",
               bus.req_done, bus.busy, bus.cmd_valid, bus.owner, bus.busy_cycles, bus.err_timeout,
               oh, g, lat, err_exp);
    end
    if (clr == 2) bus.err_clr = 1'b0;
    if (mode == 2) set_rand(g, 1'b1);
  endtask

  task automatic test_reset();
    bus.req_valid    = '0;
    bus.req_opcode   = '0;
    bus.req_slot     = '0;
    bus.req_addr     = '0;
    bus.engine_ready = 1'b1;
    bus.err_clr      = 1'b0;
    #3 rst = 1'b1;
    tick();
    tests_run++;
    if ({bus.cmd_valid, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr, bus.req_ready, bus.req_done,
         bus.busy, bus.owner, bus.busy_cycles, bus.err_timeout} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got vld=%b op=%h slot=%h addr=%h rdy=%b done=%b busy=%b own=%0d cyc=%0d err=%b, required all zero",
               bus.cmd_valid, bus.cmd_opcode, bus.cmd_slot, bus.cmd_dma_addr, bus.req_ready, bus.req_done,
               bus.busy, bus.owner, bus.busy_cycles, bus.err_timeout);
    end
    rst = 1'b0;
    model_ptr = 0;
    err_exp = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({bus.busy, bus.cmd_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got busy=%b vld=%b, required 0 0", bus.busy, bus.cmd_valid);
    end
  endtask

  task automatic test_single();
    int got;
    do_reset();
    set_req(2, 1'b1, 8'h01, 4'h3, 48'h1000);
    do_command(10, 0, 0, got);
    tests_run++;
    if (got !== 2) begin
      tests_failed++;
      $display("[TB] FAIL single_owner: got %0d, required 2", got);
    end
  endtask

  task automatic test_all_four();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int cv0;
    int r0 [NUM_REQ];
    int got;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_rand(i, 1'b1);
    cv0 = cv_count;
    for (int i = 0; i < NUM_REQ; i++) r0[i] = rdy_cnt[i];
    for (int n = 0; n < 5; n++) begin
      do_command(int'($urandom_range(1, 5)), 1, 0, got);
      tests_run++;
      if (got !== exp_order[n]) begin
        tests_failed++;
        $display("[TB] FAIL all_four_order_%0d: got %0d, required %0d", n, got, exp_order[n]);
      end
    end
    tests_run++;
    if (cv_count - cv0 !== 5) begin
      tests_failed++;
      $display("[TB] FAIL all_four_cmd_count: got %0d, required 5", cv_count - cv0);
    end
    tests_run++;
    if ({rdy_cnt[0] - r0[0], rdy_cnt[1] - r0[1], rdy_cnt[2] - r0[2], rdy_cnt[3] - r0[3]} !== {2, 1, 1, 1}) begin
      tests_failed++;
      $display("[TB] FAIL all_four_ready_count: got %0d %0d %0d %0d, required 2 1 1 1",
               rdy_cnt[0] - r0[0], rdy_cnt[1] - r0[1], rdy_cnt[2] - r0[2], rdy_cnt[3] - r0[3]);
    end
  endtask

  task automatic test_alternate();
    int exp_order [4] = '{1, 3, 1, 3};
    int r0, r2;
    int got;
    do_reset();
    set_rand(1, 1'b1);
    set_rand(3, 1'b1);
    r0 = rdy_cnt[0];
    r2 = rdy_cnt[2];
    for (int n = 0; n < 4; n++) begin
      do_command(int'($urandom_range(0, 4)), 2, 0, got);
      tests_run++;
      if (got !== exp_order[n]) begin
        tests_failed++;
        $display("[TB] FAIL alternate_order_%0d: got %0d, required %0d", n, got, exp_order[n]);
      end
    end
    tests_run++;
    if ((rdy_cnt[0] - r0) + (rdy_cnt[2] - r2) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL alternate_starved: got %0d grants to 0/2, required 0",
               (rdy_cnt[0] - r0) + (rdy_cnt[2] - r2));
    end
  endtask

  task automatic test_timeout();
    int got;
    do_reset();
    set_rand(0, 1'b1);
    do_command(TIMEOUT - 1, 2, 0, got);
    do_command(TIMEOUT, 0, 0, got);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    err_exp = 1'b0;
    tests_run++;
    if (bus.err_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clr: got %b, required 0", bus.err_timeout);
    end
    set_rand(1, 1'b1);
    do_command(TIMEOUT + 4, 0, 0, got);
    set_rand(2, 1'b1);
    do_command(TIMEOUT + 4, 0, 2, got);
  endtask

  task automatic test_ready_low_idle();
    int got;
    do_reset();
    bus.engine_ready = 1'b0;
    set_rand(0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if ({bus.cmd_valid, bus.busy, bus.req_ready} !== 6'b0) begin
        tests_failed++;
        $display("[TB] FAIL ready_low_%0d: got vld=%b busy=%b rdy=%b, required 0 0 0000",
                 k, bus.cmd_valid, bus.busy, bus.req_ready);
      end
    end
    bus.engine_ready = 1'b1;
    do_command(3, 0, 0, got);
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    set_rand(2, 1'b1);
    tick();
    set_rand(2, 1'b0);
    bus.engine_ready = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.cmd_valid, bus.req_done, bus.owner} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_async: got busy=%b vld=%b done=%b own=%0d, required all zero",
               bus.busy, bus.cmd_valid, bus.req_done, bus.owner);
    end
    bus.engine_ready = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    err_exp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({bus.req_done, bus.busy} !== 5'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_no_done_%0d: got done=%b busy=%b, required 0000 0", k, bus.req_done, bus.busy);
      end
    end
    set_rand(1, 1'b1);
    set_rand(3, 1'b1);
    do_command(5, 0, 0, got);
    tests_run++;
    if (got !== 1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_ptr: got owner %0d, required 1", got);
    end
  endtask

  task automatic test_random();
    int got;
    int lat;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i] && ($urandom % 3 == 0)) set_rand(i, 1'b1);
      if (bus.req_valid == '0) set_rand(int'($urandom % NUM_REQ), 1'b1);
      if ($urandom % 6 == 0) begin
        bus.engine_ready = 1'b0;
        repeat (1 + $urandom % 3) begin
          tick();
          tests_run++;
          if ({bus.cmd_valid, bus.busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL random_idle_%0d: got vld=%b busy=%b, required 0 0", n, bus.cmd_valid, bus.busy);
          end
        end
        bus.engine_ready = 1'b1;
      end
      lat = ($urandom % 8 == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 4)) : int'($urandom_range(0, 6));
      do_command(lat, int'($urandom % 2), ($urandom % 5 == 0) ? 1 : 0, got);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_timeout();
    test_ready_low_idle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ntt_cmd_arbiter.md
# ntt_cmd_arbiter

Round-robin command arbiter that shares one `ntt_engine` command port between `NUM_REQ` command sources, such as multiple command processors or a host queue. It accepts one command at a time and drives the engine's `cmd_valid`/`cmd_opcode`/`cmd_slot`/`cmd_dma_addr` interface. It tracks which requester owns the engine until the engine's `ready` returns, then signals completion to that owner. It also measures engine busy time and flags a hung engine with a watchdog.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `REQ_W`, 2: index width; must equal ceil(log2(`NUM_REQ`)).
- `TIMEOUT`, 65535: watchdog limit in cycles spent in WAIT_DONE; range 1..2^24-1.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester request; held with its fields until that requester's `req_ready` pulses.
- `req_opcode`  in  NUM_REQ*8  packed; requester i is bits [8i+7:8i].
- `req_slot`  in  NUM_REQ*4  packed.
- `req_addr`  in  NUM_REQ*48  packed DMA address.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- `req_done`  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- `cmd_valid`  out  1  to engine; one-cycle pulse.
- `cmd_opcode`  out  8  to engine; registered.
- `cmd_slot`  out  4  to engine; registered.
- `cmd_dma_addr`  out  48  to engine; registered.
- `engine_ready`  in  1  engine `ready` level.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  REQ_W  index of the last granted requester.
- `busy_cycles`  out  24  WAIT_DONE duration of the last completed command.
- `err_timeout`  out  1  sticky watchdog flag.
- `err_clr`  in  1  synchronous clear of `err_timeout`.

## Operation
- States: IDLE, ISSUE, HOLD, WAIT_DONE.
- IDLE, when `engine_ready`=1 and any `req_valid` is set:
  - Select the first set bit searching upward from pointer `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Latch that requester's opcode, slot and addr into the `cmd_*` registers.
  - Set `owner` to the selected index and set `rr_ptr` to (owner+1) mod `NUM_REQ`.
  - Go to ISSUE.
- IDLE with `engine_ready`=0: no grant; stay in IDLE.
- ISSUE:
  - `cmd_valid`=1 and `req_ready[owner]`=1, both for exactly this one cycle.
  - The requester may change its fields or drop `req_valid` from the next cycle.
  - Go to HOLD.
- HOLD: one cycle with `engine_ready` ignored, because the engine deasserts `ready` the cycle after it accepts a command. Clear the watchdog counter. Go to WAIT_DONE.
- WAIT_DONE:
  - The counter increments every cycle, saturating at 2^24-1.
  - When `engine_ready`=1: load `busy_cycles` with the counter value, pulse `req_done[owner]` in the next cycle, and go to IDLE.
  - When the counter reaches `TIMEOUT`: set `err_timeout`. The block stays in WAIT_DONE, with no forced release, until `engine_ready` or `rst`.
- `err_clr` and a new timeout in the same cycle: set wins.
- `cmd_*` field registers hold their value after issue; they change only on the next grant.
- Only one command is outstanding at a time. Requests raised while `busy`=1 wait and are never dropped.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `owner`=0.
  - `cmd_valid`=0, `cmd_opcode`=0, `cmd_slot`=0, `cmd_dma_addr`=0.
  - `req_ready`=0, `req_done`=0, `busy`=0.
  - `busy_cycles`=0, `err_timeout`=0, counter=0.
- Request to issue:
  - `req_valid` seen in IDLE at cycle T produces `cmd_valid` and `req_ready` at T+1.
  - HOLD is at T+2; WAIT_DONE starts at T+3.
- Completion to next issue:
  - `engine_ready`=1 sampled in WAIT_DONE at cycle D puts the block in IDLE at D+1, with `req_done` high.
  - A grant can be decided in that same IDLE cycle, so the next `cmd_valid` can appear at D+2.
- `busy_cycles` equals the number of WAIT_DONE cycles in which `engine_ready`=0.
- Reset mid-command:
  - All outputs clear asynchronously; no `req_done` is issued for the aborted command.
  - The engine shares `rst`, so it is reset in the same way.
- `req_valid` bits for indices ≥ `NUM_REQ` do not exist. Packed fields of non-selected requesters are don't-care.

## Test plan
- Single request: requester 2 with opcode 0x01, slot 3, addr 0x1000; engine busy for 10 cycles. Required: `cmd_valid` 1 cycle after the request; `req_ready[2]` coincident with `cmd_valid`; `req_done[2]` 1 cycle after `ready` returns; `busy_cycles`=10; `owner`=2.
- All 4 requesters assert from reset and keep asserting. Required: grant order 0,1,2,3,0; each requester gets exactly one `req_ready` per command; there is never more than one `cmd_valid` between `ready` rises.
- Requesters 1 and 3 assert persistently and are re-raised immediately after each `req_done`. Required: grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
- `TIMEOUT`=16 and the engine never returns `ready`. Required: `err_timeout` rises after 16 WAIT_DONE cycles and stays in WAIT_DONE. Then raise `ready`: `req_done` fires and `busy_cycles`=counter value. Then pulse `err_clr`: the flag clears.
- `engine_ready` held at 0 while in IDLE with `req_valid[0]`=1. Required: no `cmd_valid`. Raise `ready`: the grant follows 1 cycle later.
- Assert `rst` during WAIT_DONE. Required: `busy`=0, `cmd_valid`=0, `rr_ptr` back to 0, no `req_done`. A new request from requester 1 after reset is served normally.
